// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the pipeline boundary buffers: reset level, NOP payload
// and occupancy encodings used by every stage boundary.
package pipe_stage_buf_pkg;

  localparam logic RstEnable = 1'b1;

  // RISC-V addi x0,x0,0; IF/ID instances pass {pc, NOP_INSN} as BUBBLE.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready/payload bundle between two pipeline stages.
interface pipe_stage_buf_if #(
  parameter int WIDTH = 64
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stall_cnt.sv
// Saturating stall-cycle counter with a synchronous clear that beats increment.
module pipe_stall_cnt
  import pipe_stage_buf_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (inc_i && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) cnt_q <= '0;
    else                  cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline boundary buffer: valid/ready handshake, optional 2-entry skid with
// registered up-ready, flush, bubble payload when empty, and a stall counter.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int               WIDTH  = 64,
  parameter int               SKID   = 1,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 stall_clr_i,
  pipe_stage_buf_if.slave      up,
  pipe_stage_buf_if.master     dn,
  output logic [1:0]           occ_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  logic             push, pop;
  logic             up_rdy, dn_vld;
  logic [WIDTH-1:0] main_pl;
  logic [1:0]       occ;

  assign push = up.valid & up_rdy;
  assign pop  = dn_vld & dn.ready;

  if (SKID != 0) begin : gen_skid
    occ_t             occ_q, occ_d;
    logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
    logic             rdy_q;

    always_comb begin
      occ_d  = occ_q;
      main_d = main_q;
      skid_d = skid_q;
      case (occ_q)
        OCC_EMPTY: begin
          if (push) begin
            occ_d  = OCC_ONE;
            main_d = up.data;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            main_d = up.data;
          end else if (push) begin
            occ_d  = OCC_FULL;
            skid_d = up.data;
          end else if (pop) begin
            occ_d  = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            occ_d  = OCC_ONE;
            main_d = skid_q;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
      if (flush_i) occ_d = OCC_EMPTY;
    end

    // up_ready is a flop of the next occupancy so dn_ready never reaches it.
    always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
        occ_q <= OCC_EMPTY;
        rdy_q <= 1'b1;
      end else begin
        occ_q <= occ_d;
        rdy_q <= (occ_d != OCC_FULL);
      end
    end

    always_ff @(posedge clk) begin
      main_q <= main_d;
      skid_q <= skid_d;
    end

    assign up_rdy  = rdy_q;
    assign dn_vld  = (occ_q != OCC_EMPTY);
    assign occ     = occ_q;
    assign main_pl = main_q;
  end else begin : gen_single
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] main_q, main_d;

    always_comb begin
      vld_d  = vld_q;
      main_d = main_q;
      if (push) begin
        vld_d  = 1'b1;
        main_d = up.data;
      end else if (pop) begin
        vld_d  = 1'b0;
      end
      if (flush_i) vld_d = 1'b0;
    end

    always_ff @(posedge clk) begin
      if (rst == RstEnable) vld_q <= 1'b0;
      else                  vld_q <= vld_d;
    end

    always_ff @(posedge clk) begin
      main_q <= main_d;
    end

    assign up_rdy  = ~vld_q | dn.ready;
    assign dn_vld  = vld_q;
    assign occ     = {1'b0, vld_q};
    assign main_pl = main_q;
  end

  assign up.ready = up_rdy;
  assign dn.valid = dn_vld;
  assign dn.data  = dn_vld ? main_pl : BUBBLE;
  assign occ_o    = occ;

  pipe_stall_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (dn_vld & ~dn.ready),
    .clr_i (stall_clr_i),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: skid instance, single-entry instance and a
// narrow-counter instance, checked against a scoreboard and fixed expectations.
module tb_pipe_stage_buf;
  import pipe_stage_buf_pkg::*;

  localparam int          W   = 16;
  localparam logic [15:0] BUB = 16'hB0B0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_flush, a_clr, b_flush, b_clr, c_flush, c_clr;
  logic [1:0]  a_occ, b_occ, c_occ;
  logic [15:0] a_stall, b_stall;
  logic [2:0]  c_stall;

  pipe_stage_buf_if #(.WIDTH(W)) a_up();
  pipe_stage_buf_if #(.WIDTH(W)) a_dn();
  pipe_stage_buf_if #(.WIDTH(W)) b_up();
  pipe_stage_buf_if #(.WIDTH(W)) b_dn();
  pipe_stage_buf_if #(.WIDTH(W)) c_up();
  pipe_stage_buf_if #(.WIDTH(W)) c_dn();

  pipe_stage_buf #(.WIDTH(W), .SKID(1), .BUBBLE(BUB), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .flush_i(a_flush), .stall_clr_i(a_clr),
    .up(a_up), .dn(a_dn), .occ_o(a_occ), .stall_cnt_o(a_stall));

  pipe_stage_buf #(.WIDTH(W), .SKID(0), .BUBBLE(BUB), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .flush_i(b_flush), .stall_clr_i(b_clr),
    .up(b_up), .dn(b_dn), .occ_o(b_occ), .stall_cnt_o(b_stall));

  pipe_stage_buf #(.WIDTH(W), .SKID(1), .BUBBLE(BUB), .CNT_W(3)) u_c (
    .clk(clk), .rst(rst), .flush_i(c_flush), .stall_clr_i(c_clr),
    .up(c_up), .dn(c_dn), .occ_o(c_occ), .stall_cnt_o(c_stall));

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] sb[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_up.valid = 1'b1; a_up.data = 16'h1234; a_dn.ready = 1'b0;
    b_up.valid = 1'b1; b_up.data = 16'h1234; b_dn.ready = 1'b0;
    c_up.valid = 1'b1; c_up.data = 16'h1234; c_dn.ready = 1'b0;
    tick; tick;
    rst = 1'b0;
    a_up.valid = 1'b0; b_up.valid = 1'b0; c_up.valid = 1'b0;
    n_chk++; if (a_dn.valid !== 1'b0) begin n_fail++; $display("FAIL rst_a_valid: got %b want 0", a_dn.valid); end
    n_chk++; if (a_dn.data !== BUB) begin n_fail++; $display("FAIL rst_a_data: got %h want %h", a_dn.data, BUB); end
    n_chk++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL rst_a_occ: got %0d want 0", a_occ); end
    n_chk++; if (a_up.ready !== 1'b1) begin n_fail++; $display("FAIL rst_a_ready: got %b want 1", a_up.ready); end
    n_chk++; if (a_stall !== 16'd0) begin n_fail++; $display("FAIL rst_a_stall: got %0d want 0", a_stall); end
    n_chk++; if (b_up.ready !== 1'b1 || b_dn.valid !== 1'b0 || b_dn.data !== BUB) begin
      n_fail++; $display("FAIL rst_b: got rdy=%b vld=%b data=%h want 1 0 %h", b_up.ready, b_dn.valid, b_dn.data, BUB); end
    // fill A, then reset with a push still being offered
    a_up.valid = 1'b1; a_up.data = 16'h0001; tick;
    a_up.data = 16'h0002; tick;
    n_chk++; if (a_occ !== 2'd2) begin n_fail++; $display("FAIL rst_pre_full: got %0d want 2", a_occ); end
    rst = 1'b1; a_up.data = 16'h0003; tick;
    rst = 1'b0; a_up.valid = 1'b0;
    n_chk++; if (a_occ !== 2'd0 || a_dn.valid !== 1'b0 || a_up.ready !== 1'b1 || a_stall !== 16'd0) begin
      n_fail++; $display("FAIL rst_mid: got occ=%0d vld=%b rdy=%b stall=%0d want 0 0 1 0", a_occ, a_dn.valid, a_up.ready, a_stall); end
  endtask

  task automatic test_streaming;
    logic [15:0] exp;
    sb.delete();
    for (int i = 0; i < 10; i++) begin
      a_dn.ready = 1'b1;
      a_up.valid = (i < 8);
      a_up.data  = 16'hA0 + 16'(i);
      n_chk++; if (a_dn.valid !== (i >= 1 && i <= 8)) begin
        n_fail++; $display("FAIL stream_valid[%0d]: got %b want %b", i, a_dn.valid, (i >= 1 && i <= 8)); end
      if (i >= 1 && i <= 8) begin
        n_chk++; if (a_occ !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, a_occ); end
      end
      if (a_dn.valid === 1'b1) begin
        n_chk++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL stream_extra: got %h want none", a_dn.data); end
        else begin
          exp = sb.pop_front();
          if (a_dn.data !== exp) begin n_fail++; $display("FAIL stream_data: got %h want %h", a_dn.data, exp); end
        end
      end
      if (a_up.valid && a_up.ready) sb.push_back(a_up.data);
      tick;
    end
    a_up.valid = 1'b0;
    n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL stream_left: got %0d want 0", sb.size()); end
  endtask

  task automatic test_backpressure;
    logic [15:0] pend[$];
    logic [15:0] exp;
    sb.delete();
    pend = '{16'h11, 16'h22, 16'h33};
    for (int c = 0; c < 10; c++) begin
      a_dn.ready = (c >= 5);
      a_up.valid = (pend.size() != 0);
      a_up.data  = (pend.size() != 0) ? pend[0] : 16'h0;
      if (c == 2 || c == 3) begin
        n_chk++; if (a_occ !== 2'd2 || a_up.ready !== 1'b0) begin
          n_fail++; $display("FAIL bp_full[%0d]: got occ=%0d rdy=%b want 2 0", c, a_occ, a_up.ready); end
      end
      if (a_dn.valid && a_dn.ready) begin
        n_chk++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL bp_extra: got %h want none", a_dn.data); end
        else begin
          exp = sb.pop_front();
          if (a_dn.data !== exp) begin n_fail++; $display("FAIL bp_data: got %h want %h", a_dn.data, exp); end
        end
      end
      if (a_up.valid && a_up.ready) sb.push_back(pend.pop_front());
      tick;
    end
    a_up.valid = 1'b0;
    n_chk++; if (sb.size() != 0 || pend.size() != 0) begin
      n_fail++; $display("FAIL bp_drain: got sb=%0d pend=%0d want 0 0", sb.size(), pend.size()); end
    n_chk++; if (a_stall !== 16'd4) begin n_fail++; $display("FAIL bp_stall: got %0d want 4", a_stall); end
  endtask

  task automatic test_flush;
    a_dn.ready = 1'b0; a_flush = 1'b0;
    a_up.valid = 1'b1; a_up.data = 16'h55; tick;
    a_up.data = 16'h66; tick;
    n_chk++; if (a_occ !== 2'd2) begin n_fail++; $display("FAIL fl_pre: got %0d want 2", a_occ); end
    a_flush = 1'b1; a_up.data = 16'h77; tick;
    a_flush = 1'b0; a_up.valid = 1'b0;
    n_chk++; if (a_occ !== 2'd0 || a_dn.valid !== 1'b0 || a_dn.data !== BUB) begin
      n_fail++; $display("FAIL fl_post: got occ=%0d vld=%b data=%h want 0 0 %h", a_occ, a_dn.valid, a_dn.data, BUB); end
    n_chk++; if (a_stall !== 16'd6) begin n_fail++; $display("FAIL fl_stall: got %0d want 6", a_stall); end
    a_dn.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (a_dn.valid !== 1'b0) begin n_fail++; $display("FAIL fl_ghost[%0d]: got %h want none", i, a_dn.data); end
      tick;
    end
    a_up.valid = 1'b1; a_up.data = 16'h78; tick;
    a_up.valid = 1'b0;
    n_chk++; if (a_dn.valid !== 1'b1 || a_dn.data !== 16'h78) begin
      n_fail++; $display("FAIL fl_resume: got vld=%b data=%h want 1 0078", a_dn.valid, a_dn.data); end
    n_chk++; if (a_stall !== 16'd6) begin n_fail++; $display("FAIL fl_stall_hold: got %0d want 6", a_stall); end
  endtask

  task automatic test_skid0;
    b_dn.ready = 1'b0; b_up.valid = 1'b1; b_up.data = 16'h88;
    #1;
    n_chk++; if (b_up.ready !== 1'b1) begin n_fail++; $display("FAIL s0_empty_rdy: got %b want 1", b_up.ready); end
    tick;
    b_up.data = 16'h99;
    #1;
    n_chk++; if (b_dn.valid !== 1'b1 || b_dn.data !== 16'h88) begin
      n_fail++; $display("FAIL s0_hold: got vld=%b data=%h want 1 0088", b_dn.valid, b_dn.data); end
    n_chk++; if (b_up.ready !== 1'b0) begin n_fail++; $display("FAIL s0_block: got %b want 0", b_up.ready); end
    b_dn.ready = 1'b1;
    #1;
    n_chk++; if (b_up.ready !== 1'b1) begin n_fail++; $display("FAIL s0_comb_rdy: got %b want 1", b_up.ready); end
    tick;
    b_up.valid = 1'b0;
    n_chk++; if (b_dn.valid !== 1'b1 || b_dn.data !== 16'h99 || b_occ !== 2'd1) begin
      n_fail++; $display("FAIL s0_next: got vld=%b data=%h occ=%0d want 1 0099 1", b_dn.valid, b_dn.data, b_occ); end
    tick;
    n_chk++; if (b_dn.valid !== 1'b0 || b_dn.data !== BUB || b_occ !== 2'd0) begin
      n_fail++; $display("FAIL s0_drain: got vld=%b data=%h occ=%0d want 0 %h 0", b_dn.valid, b_dn.data, b_occ, BUB); end
    n_chk++; if (b_stall !== 16'd0) begin n_fail++; $display("FAIL s0_stall: got %0d want 0", b_stall); end
  endtask

  task automatic test_saturation;
    logic [2:0] exp;
    c_dn.ready = 1'b0; c_clr = 1'b0;
    c_up.valid = 1'b1; c_up.data = 16'h42; tick;
    c_up.valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      exp = (k - 1 > 7) ? 3'd7 : 3'(k - 1);
      n_chk++; if (c_stall !== exp) begin n_fail++; $display("FAIL sat[%0d]: got %0d want %0d", k, c_stall, exp); end
      tick;
    end
    n_chk++; if (c_stall !== 3'd7 || c_dn.data !== 16'h42) begin
      n_fail++; $display("FAIL sat_top: got cnt=%0d data=%h want 7 0042", c_stall, c_dn.data); end
    c_clr = 1'b1; tick;
    c_clr = 1'b0;
    n_chk++; if (c_stall !== 3'd0) begin n_fail++; $display("FAIL sat_clr: got %0d want 0", c_stall); end
    tick;
    n_chk++; if (c_stall !== 3'd1) begin n_fail++; $display("FAIL sat_restart: got %0d want 1", c_stall); end
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_clr = 1'b0; b_flush = 1'b0; b_clr = 1'b0; c_flush = 1'b0; c_clr = 1'b0;
    a_up.valid = 1'b0; a_up.data = '0; a_dn.ready = 1'b0;
    b_up.valid = 1'b0; b_up.data = '0; b_dn.ready = 1'b0;
    c_up.valid = 1'b0; c_up.data = '0; c_dn.ready = 1'b0;
    #1;
    test_reset;
    test_streaming;
    test_backpressure;
    test_flush;
    test_skid0;
    test_saturation;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline boundary buffer for the in-order core: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Replaces the per-stage stall-vector registers with a valid/ready handshake, a 2-entry skid option, a flush input and bubble insertion.
- Adds a saturating stall-cycle counter for performance debug.
- Upstream stage drives the up_* side; downstream stage consumes the dn_* side.

Parameters:
- WIDTH, 64, payload width in bits (e.g. {pc, inst} for IF/ID).
- SKID, 1, 1 = 2-entry skid buffer with registered up_ready; 0 = single register with combinational up_ready.
- BUBBLE, 0, payload value presented on dn_data while dn_valid=0 (NOP encoding may be supplied).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all buffered entries (branch/jump redirect)
- up_valid  in  1  upstream offers up_data
- up_ready  out  1  buffer accepts this cycle
- up_data  in  WIDTH  payload from upstream
- dn_valid  out  1  dn_data is valid
- dn_ready  in  1  downstream consumes this cycle
- dn_data  out  WIDTH  payload to downstream; equals BUBBLE when dn_valid=0
- occ  out  2  entries held (0..2; max 1 when SKID=0)
- stall_cnt  out  CNT_W  cycles with dn_valid=1 and dn_ready=0, saturating
- stall_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- Handshakes:
  - Push = up_valid & up_ready. Pop = dn_valid & dn_ready.
  - Transfers are evaluated on the rising clk edge.
  - Data is never duplicated or lost except by flush.
- Reset (rst=1 at posedge):
  - Entries are invalidated and stall_cnt=0.
  - Next cycle: dn_valid=0, dn_data=BUBBLE, occ=0.
  - up_ready=1 with SKID=1; with SKID=0 it follows the combinational rule.
  - Reset mid-transfer drops both the entry in flight and any held entries.
- SKID=1 states, encoded by occ:
  - EMPTY (0):
    - push -> ONE (main=up_data).
  - ONE (1):
    - push&pop -> ONE (main=up_data).
    - push&!pop -> FULL (skid=up_data).
    - !push&pop -> EMPTY.
    - otherwise hold.
  - FULL (2): up_ready=0, so no push.
    - pop -> ONE (main<=skid).
    - otherwise hold.
  - up_ready = (occ!=2), driven from a register; no combinational path from dn_ready.
  - Latency: up_data seen on dn_data the cycle after push. Throughput: 1/cycle.
- SKID=0:
  - Single entry.
  - up_ready = !dn_valid | dn_ready (combinational).
  - push overwrites main; pop without push clears valid.
- Flush:
  - Invalidates all entries at the edge; a coincident push is discarded.
  - Next cycle: occ=0, dn_valid=0, dn_data=BUBBLE.
  - flush has priority over push/pop; rst has priority over flush.
- dn_data = main payload when dn_valid, else BUBBLE. Payload registers need not be cleared on flush.
- Stall counter:
  - stall_cnt increments when dn_valid&!dn_ready and stall_cnt != all-ones.
  - Holds at 2^CNT_W-1.
  - stall_clr has priority over increment; rst clears it.
  - flush does not clear it.
- Order of entries: strict FIFO; main always holds the older entry.

Decomposition:
- Shared package (defines header):
  - RstEnable.
  - NOP encoding (default BUBBLE for IF/ID).
  - occupancy constants OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2.
- One natural sub-module: pipe_stall_cnt, the saturating counter with clear (CNT_W parameter).
- Payload/valid storage stays in the top.

Test Plan:
- Reset: assert rst 2 cycles with up_valid=1, up_data=0x1234 -> after release dn_valid=0, dn_data=BUBBLE, occ=0, up_ready=1, stall_cnt=0.
- Streaming: dn_ready=1, push 0xA0..0xA7 back-to-back -> dn_data=0xA0..0xA7 on consecutive cycles, each 1 cycle after push, occ stays 1.
- Backpressure (SKID=1): push 0x11, 0x22, 0x33 with dn_ready=0 -> occ=2 after 2 pushes, up_ready=0, 0x33 held upstream. Release dn_ready -> 0x11, 0x22, 0x33 in order; stall_cnt equals the number of dn_ready=0 cycles with dn_valid=1.
- Flush: occ=2 holding 0x55, 0x66; flush=1 with push 0x77 -> next cycle occ=0, dn_valid=0, dn_data=BUBBLE. 0x77 never appears, and stall_cnt is unchanged.
- SKID=0 instance: dn_ready=0 with dn_valid=1 -> up_ready=0 in the same cycle. dn_ready=1 with push 0x99 -> up_ready=1 combinationally and dn_data=0x99 next cycle.
- Counter saturation (CNT_W=3): hold dn_ready=0 for 10 cycles with a valid entry -> stall_cnt stops at 7; stall_clr=1 -> 0 next cycle.
